des_ecb_dec_iter: RTL and testbench

//  Iterative DES decryptor for ECB mode: one Feistel round per clock, 16 rounds per block.

---
 rtl/des_pkg.sv | 137 +++++++++++++
 rtl/des_round_f.sv | 27 ++
 rtl/des_ecb_dec_iter.sv | 107 ++++++++++
 tb/tb_des_ecb_dec_iter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES constants: FIPS 46 permutation tables, S-boxes, key schedule and FSM states.
// Vectors are [N:1] with bit N holding DES bit 1, so DES bit k of an N-bit word sits at index N+1-k.
package des_pkg;

   localparam int unsigned ROUNDS = 16;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam int unsigned IP_T [64] = '{
      58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
      62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
      57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
      61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};

   localparam int unsigned FP_T [64] = '{
      40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
      38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
      36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
      34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};

   localparam int unsigned E_T [48] = '{
      32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

   localparam int unsigned P_T [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

   localparam int unsigned PC1_T [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

   localparam int unsigned PC2_T [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   // Encryption left-shift amounts for rounds 1..16 (index 0 = round 1).
   localparam logic [1:0] LS_T [16] = '{
      2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

   // Each S-box flattened row-major: entry = row*16 + column.
   localparam logic [3:0] SBOX [8][64] = '{
      '{4'd14, 4'd4, 4'd13, 4'd1, 4'd2, 4'd15, 4'd11, 4'd8, 4'd3, 4'd10, 4'd6, 4'd12, 4'd5, 4'd9, 4'd0, 4'd7,
        4'd0, 4'd15, 4'd7, 4'd4, 4'd14, 4'd2, 4'd13, 4'd1, 4'd10, 4'd6, 4'd12, 4'd11, 4'd9, 4'd5, 4'd3, 4'd8,
        4'd4, 4'd1, 4'd14, 4'd8, 4'd13, 4'd6, 4'd2, 4'd11, 4'd15, 4'd12, 4'd9, 4'd7, 4'd3, 4'd10, 4'd5, 4'd0,
        4'd15, 4'd12, 4'd8, 4'd2, 4'd4, 4'd9, 4'd1, 4'd7, 4'd5, 4'd11, 4'd3, 4'd14, 4'd10, 4'd0, 4'd6, 4'd13},
      '{4'd15, 4'd1, 4'd8, 4'd14, 4'd6, 4'd11, 4'd3, 4'd4, 4'd9, 4'd7, 4'd2, 4'd13, 4'd12, 4'd0, 4'd5, 4'd10,
        4'd3, 4'd13, 4'd4, 4'd7, 4'd15, 4'd2, 4'd8, 4'd14, 4'd12, 4'd0, 4'd1, 4'd10, 4'd6, 4'd9, 4'd11, 4'd5,
        4'd0, 4'd14, 4'd7, 4'd11, 4'd10, 4'd4, 4'd13, 4'd1, 4'd5, 4'd8, 4'd12, 4'd6, 4'd9, 4'd3, 4'd2, 4'd15,
        4'd13, 4'd8, 4'd10, 4'd1, 4'd3, 4'd15, 4'd4, 4'd2, 4'd11, 4'd6, 4'd7, 4'd12, 4'd0, 4'd5, 4'd14, 4'd9},
      '{4'd10, 4'd0, 4'd9, 4'd14, 4'd6, 4'd3, 4'd15, 4'd5, 4'd1, 4'd13, 4'd12, 4'd7, 4'd11, 4'd4, 4'd2, 4'd8,
        4'd13, 4'd7, 4'd0, 4'd9, 4'd3, 4'd4, 4'd6, 4'd10, 4'd2, 4'd8, 4'd5, 4'd14, 4'd12, 4'd11, 4'd15, 4'd1,
        4'd13, 4'd6, 4'd4, 4'd9, 4'd8, 4'd15, 4'd3, 4'd0, 4'd11, 4'd1, 4'd2, 4'd12, 4'd5, 4'd10, 4'd14, 4'd7,
        4'd1, 4'd10, 4'd13, 4'd0, 4'd6, 4'd9, 4'd8, 4'd7, 4'd4, 4'd15, 4'd14, 4'd3, 4'd11, 4'd5, 4'd2, 4'd12},
      '{4'd7, 4'd13, 4'd14, 4'd3, 4'd0, 4'd6, 4'd9, 4'd10, 4'd1, 4'd2, 4'd8, 4'd5, 4'd11, 4'd12, 4'd4, 4'd15,
        4'd13, 4'd8, 4'd11, 4'd5, 4'd6, 4'd15, 4'd0, 4'd3, 4'd4, 4'd7, 4'd2, 4'd12, 4'd1, 4'd10, 4'd14, 4'd9,
        4'd10, 4'd6, 4'd9, 4'd0, 4'd12, 4'd11, 4'd7, 4'd13, 4'd15, 4'd1, 4'd3, 4'd14, 4'd5, 4'd2, 4'd8, 4'd4,
        4'd3, 4'd15, 4'd0, 4'd6, 4'd10, 4'd1, 4'd13, 4'd8, 4'd9, 4'd4, 4'd5, 4'd11, 4'd12, 4'd7, 4'd2, 4'd14},
      '{4'd2, 4'd12, 4'd4, 4'd1, 4'd7, 4'd10, 4'd11, 4'd6, 4'd8, 4'd5, 4'd3, 4'd15, 4'd13, 4'd0, 4'd14, 4'd9,
        4'd14, 4'd11, 4'd2, 4'd12, 4'd4, 4'd7, 4'd13, 4'd1, 4'd5, 4'd0, 4'd15, 4'd10, 4'd3, 4'd9, 4'd8, 4'd6,
        4'd4, 4'd2, 4'd1, 4'd11, 4'd10, 4'd13, 4'd7, 4'd8, 4'd15, 4'd9, 4'd12, 4'd5, 4'd6, 4'd3, 4'd0, 4'd14,
        4'd11, 4'd8, 4'd12, 4'd7, 4'd1, 4'd14, 4'd2, 4'd13, 4'd6, 4'd15, 4'd0, 4'd9, 4'd10, 4'd4, 4'd5, 4'd3},
      '{4'd12, 4'd1, 4'd10, 4'd15, 4'd9, 4'd2, 4'd6, 4'd8, 4'd0, 4'd13, 4'd3, 4'd4, 4'd14, 4'd7, 4'd5, 4'd11,
        4'd10, 4'd15, 4'd4, 4'd2, 4'd7, 4'd12, 4'd9, 4'd5, 4'd6, 4'd1, 4'd13, 4'd14, 4'd0, 4'd11, 4'd3, 4'd8,
        4'd9, 4'd14, 4'd15, 4'd5, 4'd2, 4'd8, 4'd12, 4'd3, 4'd7, 4'd0, 4'd4, 4'd10, 4'd1, 4'd13, 4'd11, 4'd6,
        4'd4, 4'd3, 4'd2, 4'd12, 4'd9, 4'd5, 4'd15, 4'd10, 4'd11, 4'd14, 4'd1, 4'd7, 4'd6, 4'd0, 4'd8, 4'd13},
      '{4'd4, 4'd11, 4'd2, 4'd14, 4'd15, 4'd0, 4'd8, 4'd13, 4'd3, 4'd12, 4'd9, 4'd7, 4'd5, 4'd10, 4'd6, 4'd1,
        4'd13, 4'd0, 4'd11, 4'd7, 4'd4, 4'd9, 4'd1, 4'd10, 4'd14, 4'd3, 4'd5, 4'd12, 4'd2, 4'd15, 4'd8, 4'd6,
        4'd1, 4'd4, 4'd11, 4'd13, 4'd12, 4'd3, 4'd7, 4'd14, 4'd10, 4'd15, 4'd6, 4'd8, 4'd0, 4'd5, 4'd9, 4'd2,
        4'd6, 4'd11, 4'd13, 4'd8, 4'd1, 4'd4, 4'd10, 4'd7, 4'd9, 4'd5, 4'd0, 4'd15, 4'd14, 4'd2, 4'd3, 4'd12},
      '{4'd13, 4'd2, 4'd8, 4'd4, 4'd6, 4'd15, 4'd11, 4'd1, 4'd10, 4'd9, 4'd3, 4'd14, 4'd5, 4'd0, 4'd12, 4'd7,
        4'd1, 4'd15, 4'd13, 4'd8, 4'd10, 4'd3, 4'd7, 4'd4, 4'd12, 4'd5, 4'd6, 4'd11, 4'd0, 4'd14, 4'd9, 4'd2,
        4'd7, 4'd11, 4'd4, 4'd1, 4'd9, 4'd12, 4'd14, 4'd2, 4'd0, 4'd6, 4'd10, 4'd13, 4'd15, 4'd3, 4'd5, 4'd8,
        4'd2, 4'd1, 4'd14, 4'd7, 4'd4, 4'd10, 4'd8, 4'd13, 4'd15, 4'd12, 4'd9, 4'd0, 4'd3, 4'd5, 4'd6, 4'd11}};

   function automatic logic [64:1] ip(input logic [64:1] x);
      logic [64:1] y;
      y = '0;
      for (int unsigned i = 0; i < 64; i++) y[64-i] = x[65-IP_T[i]];
      return y;
   endfunction

   function automatic logic [64:1] fp(input logic [64:1] x);
      logic [64:1] y;
      y = '0;
      for (int unsigned i = 0; i < 64; i++) y[64-i] = x[65-FP_T[i]];
      return y;
   endfunction

   function automatic logic [48:1] e_expand(input logic [32:1] x);
      logic [48:1] y;
      y = '0;
      for (int unsigned i = 0; i < 48; i++) y[48-i] = x[33-E_T[i]];
      return y;
   endfunction

   function automatic logic [32:1] p_perm(input logic [32:1] x);
      logic [32:1] y;
      y = '0;
      for (int unsigned i = 0; i < 32; i++) y[32-i] = x[33-P_T[i]];
      return y;
   endfunction

   function automatic logic [56:1] pc1(input logic [64:1] x);
      logic [56:1] y;
      y = '0;
      for (int unsigned i = 0; i < 56; i++) y[56-i] = x[65-PC1_T[i]];
      return y;
   endfunction

   function automatic logic [48:1] pc2(input logic [56:1] x);
      logic [48:1] y;
      y = '0;
      for (int unsigned i = 0; i < 48; i++) y[48-i] = x[57-PC2_T[i]];
      return y;
   endfunction

   // Right-rotate amount for decryption round j: none in round 1, else LS(18-j).
   function automatic logic [1:0] dec_shift(input logic [4:0] j);
      logic [1:0] s;
      s = 2'd0;
      if (j >= 5'd2 && j <= 5'd16) s = LS_T[5'd17 - j];
      return s;
   endfunction

endpackage

// File: rtl/des_round_f.sv
// DES round function f(R, K): E-expansion, subkey XOR, S1..S8 substitution, P permutation.
// Purely combinational so encrypt/decrypt and chained-mode cores can share it.
module des_round_f
   import des_pkg::*;
(
   input  logic [32:1] r,
   input  logic [48:1] k,
   output logic [32:1] f
);

   logic [48:1] x;
   logic [32:1] s;
   logic [6:1]  b;

   always_comb begin
      x = e_expand(r) ^ k;
      s = '0;
      b = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         b = x[48-6*i -: 6];
         // Outer bits pick the row, inner four the column.
         s[32-4*i -: 4] = SBOX[i][{b[6], b[1], b[5:2]}];
      end
      f = p_perm(s);
   end

endmodule

// File: rtl/des_ecb_dec_iter.sv
// Iterative DES ECB decryptor: one Feistel round per clock, 16 rounds per block,
// valid/ready handshake on both the ciphertext input and the plaintext output.
module des_ecb_dec_iter
   import des_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [64:1] ciphertext,
   input  logic [64:1] key,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [64:1] plaintext
);

   state_t      state, state_nx;
   logic [4:0]  ctr;
   logic [32:1] l, r;
   logic [28:1] c, d;
   logic [28:1] c_rot, d_rot;
   logic [48:1] subkey;
   logic [32:1] f_out;
   logic [32:1] r_new;
   logic        last;

   assign last      = (ctr == 5'(ROUNDS));
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (in_valid)  state_nx = RUN;
         RUN:     if (last)      state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Key schedule runs backwards: round 1 uses PC1(key) unrotated (K16), later rounds rotate right.
   always_comb begin
      c_rot = c;
      d_rot = d;
      unique case (dec_shift(ctr))
         2'd1: begin
            c_rot = {c[1], c[28:2]};
            d_rot = {d[1], d[28:2]};
         end
         2'd2: begin
            c_rot = {c[2:1], c[28:3]};
            d_rot = {d[2:1], d[28:3]};
         end
         default: ;
      endcase
      subkey = pc2({c_rot, d_rot});
      r_new  = l ^ f_out;
   end

   des_round_f u_f (
      .r (r),
      .k (subkey),
      .f (f_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         l         <= '0;
         r         <= '0;
         c         <= '0;
         d         <= '0;
         ctr       <= '0;
         plaintext <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  {l, r} <= ip(ciphertext);
                  {c, d} <= pc1(key);
                  ctr    <= 5'd1;
               end
            end
            RUN: begin
               l   <= r;
               r   <= r_new;
               c   <= c_rot;
               d   <= d_rot;
               ctr <= ctr + 5'd1;
               if (last) begin
                  plaintext <= fp({r_new, r});
                  ctr       <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   ctr_range_a: assert property (@(posedge clk) disable iff (rst)
      (state == RUN) |-> (ctr >= 5'd1 && ctr <= 5'(ROUNDS)));

endmodule

// File: tb/tb_des_ecb_dec_iter.sv
// Directed bench for des_ecb_dec_iter using published DES known-answer vectors.
module tb_des_ecb_dec_iter;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [64:1] ciphertext;
   logic [64:1] key;
   logic        out_valid;
   logic        out_ready;
   logic [64:1] plaintext;

   int unsigned errors;
   int unsigned checks;

   des_ecb_dec_iter dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .ciphertext (ciphertext),
      .key        (key),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .plaintext  (plaintext)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one block, scramble the inputs right after acceptance, hold out_ready low
   // for 'hold' cycles once out_valid rises, then release.
   task automatic run_block(input logic [64:1] k, input logic [64:1] ct,
                            input logic [64:1] exp, input int unsigned hold, input string tag);
      int unsigned n;
      logic [64:1] held;
      n = 0;
      key = k;
      ciphertext = ct;
      in_valid = 1'b1;
      while (!in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk(64'(in_ready), 64'd1, {tag, "_in_ready"});
      @(negedge clk);
      in_valid = 1'b0;
      key = {$urandom, $urandom};
      ciphertext = {$urandom, $urandom};
      n = 1;
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk(64'(n), 64'd17, {tag, "_latency"});
      chk(plaintext, exp, {tag, "_pt"});
      chk(64'(in_ready), 64'd0, {tag, "_busy"});
      held = plaintext;
      for (int unsigned i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         key = {$urandom, $urandom};
         ciphertext = {$urandom, $urandom};
         @(negedge clk);
         chk(plaintext, held, {tag, "_hold_pt"});
         chk(64'(in_ready), 64'd0, {tag, "_hold_rdy"});
         chk(64'(out_valid), 64'd1, {tag, "_hold_vld"});
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk(64'(out_valid), 64'd0, {tag, "_release_vld"});
      chk(64'(in_ready), 64'd1, {tag, "_release_rdy"});
      if (in_valid) begin
         // in_valid stayed high across the DONE->IDLE edge; it must not have been taken.
         in_valid = 1'b0;
         @(negedge clk);
         chk(64'(in_ready), 64'd1, {tag, "_no_reload"});
      end
   endtask

   initial begin
      int unsigned first;
      int unsigned second;
      bit          seen;
      errors = 0;
      checks = 0;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      key = '0;
      ciphertext = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk(64'(in_ready), 64'd1, "reset_in_ready");
      chk(64'(out_valid), 64'd0, "reset_out_valid");
      chk(plaintext, 64'h0, "reset_plaintext");

      run_block(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF, 0, "kat1");
      run_block(64'h0E329232EA6D0D73, 64'h0000000000000000, 64'h8787878787878787, 0, "kat2");
      run_block(64'h123556789ABDDEF0, 64'h85E813540F0AB405, 64'h0123456789ABCDEF, 0, "parity");
      run_block(64'h0123456789ABCDEF, 64'h3FA40E8A984D4815, 64'h4E6F772069732074, 10, "backpressure");
      run_block(64'h0101010101010101, 64'h8CA64DE9C1B123A7, 64'h0000000000000000, 0, "zero_key");
      run_block(64'hFEFEFEFEFEFEFEFE, 64'h7359B2163E4EDC58, 64'hFFFFFFFFFFFFFFFF, 0, "ones_key");

      // Reset during round 8 discards the block.
      key = 64'h133457799BBCDFF1;
      ciphertext = 64'h85E813540F0AB405;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk(64'(in_ready), 64'd1, "midreset_in_ready");
      chk(64'(out_valid), 64'd0, "midreset_out_valid");
      chk(plaintext, 64'h0, "midreset_plaintext");
      seen = 1'b0;
      for (int unsigned i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk(64'(seen), 64'd0, "midreset_no_pulse");
      run_block(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF, 0, "after_reset");

      // Streaming with both sides always ready: one block per 18 cycles.
      key = 64'h133457799BBCDFF1;
      ciphertext = 64'h85E813540F0AB405;
      in_valid = 1'b1;
      out_ready = 1'b1;
      first = 0;
      second = 0;
      for (int unsigned i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (out_valid) begin
            if (first == 0) first = i;
            else if (second == 0) second = i;
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk(64'(second - first), 64'd18, "throughput");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
